uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte sources, e.g. the command echo path, the status reporter and the debug dumper.
- Sits between the requesters and the uart_tx instance. Selects sources round-robin, presents one byte at a time to the transmitter and sequences the start/busy handshake.
- Supports a packet lock so a multi-byte message from one source is never interleaved with bytes from another source.

Parameters:
- NUM_REQ, 4: number of requesters; allowed range 2..8.
- DATA_W, 8: byte width.
- ACK_TIMEOUT, 16: maximum cycles to wait for tx_busy to rise after tx_start.
- LOCK_TIMEOUT, 65535: idle cycles after which a stalled lock owner loses its lock.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-source request; bit i high means req_data slice i holds a valid byte.
- req_last  in  NUM_REQ  per-source flag; high means the offered byte is the last byte of its packet.
- req_data  in  NUM_REQ*DATA_W  packed bytes; slice i is bits [i*DATA_W +: DATA_W].
- grant  out  NUM_REQ  one-hot, one-cycle pulse meaning the byte from source i was consumed.
- tx_data  out  DATA_W  byte to the transmitter.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_busy  in  1  transmitter busy flag.
- owner  out  clog2(NUM_REQ)  index of the most recently granted source.
- locked  out  1  high while a packet lock is held.
- arb_busy  out  1  high whenever the state is not IDLE.
- ack_err  out  1  one-cycle pulse when ACK_TIMEOUT expires.

Behaviour:
- Reset (async assert, sync release):
  - grant=0, tx_data=0, tx_start=0, owner=0, locked=0, arb_busy=0, ack_err=0.
  - State IDLE, timeout counter 0.
  - Round-robin pointer last = NUM_REQ-1, so source 0 has first priority.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE, unlocked:
  - Search order is last+1, last+2, … modulo NUM_REQ; the first source with req high wins (index i).
  - On that edge: grant[i]=1, tx_data=slice i, owner=i, last=i, locked=!req_last[i]; go to ISSUE.
- IDLE, locked:
  - Only source owner is eligible.
  - If req[owner] is high: grant it as above; the counter clears.
  - Else the counter increments. When it reaches LOCK_TIMEOUT: locked=0, counter clears, no grant that cycle.
- ISSUE:
  - grant returns to 0, tx_start=1 for exactly one cycle, counter clears; go to WAIT_ACK.
- WAIT_ACK:
  - tx_busy high: go to WAIT_DONE.
  - Counter reaches ACK_TIMEOUT with tx_busy still low: ack_err pulses one cycle, locked=0, go to IDLE. The byte is considered lost; it is not regranted.
- WAIT_DONE:
  - tx_busy low: go to IDLE.
  - Earliest next grant is on the following edge.
- Latency and handshake timing:
  - req seen in IDLE at edge k gives grant at k+1 and tx_start at k+2.
  - Minimum spacing between grants is 3 cycles plus the transmitter busy time.
- Requester rules:
  - Hold req and req_data stable until grant is seen.
  - May change them in the cycle after grant.
  - tx_data stays stable from grant until the next grant.
- Deasserting req before grant withdraws the request; no grant is issued for it.
- When a locked owner's grant carries req_last=1, locked clears in the same edge, and the next arbitration is round-robin from last.
- tx_busy already high in IDLE is ignored; the arbiter still issues, and WAIT_ACK exits immediately.
- Reset asserted mid-operation returns everything to reset values at once. A tx_start pulse in flight is cut.

Test Plan:
- Single source: req=0001, req_data[7:0]=0x41, req_last=1 → grant=0001 at k+1, tx_data=0x41, tx_start at k+2; model transmitter busy 10 cycles → arb_busy drops after tx_busy falls.
- Fairness: req=1111 held with req_last=1111 for 8 bytes → grant order 0,1,2,3,0,1,2,3; no source granted twice before all others are served.
- Packet lock: source 2 sends 3 bytes (req_last 0,0,1) while source 0 requests continuously → grants 2,2,2 then 0; locked=1 between bytes 1 and 3.
- Lock timeout with LOCK_TIMEOUT=8: source 1 sends one byte with req_last=0, then drops req while source 3 requests → locked clears after 8 idle cycles, then grant=1000.
- Ack timeout with ACK_TIMEOUT=4: tx_busy tied low → ack_err pulses 4 cycles after tx_start, state returns to IDLE, next request is granted normally.
- Reset mid-transfer: assert reset_n=0 during WAIT_DONE → all outputs reset immediately; after release, req=0100 gets grant=0100 (pointer back to NUM_REQ-1, so source 0 would win over source 2 if both request).

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources: round-robin
// selection, optional packet lock, and start/busy handshake sequencing.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int ACK_TIMEOUT  = 16,
  parameter int LOCK_TIMEOUT = 65535,
  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  output logic [IDX_W-1:0]          owner,
  output logic                      locked,
  output logic                      arb_busy,
  output logic                      ack_err
);

  localparam int CNT_MAX = (LOCK_TIMEOUT > ACK_TIMEOUT) ? LOCK_TIMEOUT : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_INIT  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [IDX_W-1:0]      last, last_nxt;
  logic [NUM_REQ-1:0]    grant_nxt;
  logic [DATA_W-1:0]     tx_data_nxt;
  logic                  tx_start_nxt;
  logic [IDX_W-1:0]      owner_nxt;
  logic                  locked_nxt;
  logic                  ack_err_nxt;

  logic [DATA_W-1:0]     slices [NUM_REQ];
  logic [IDX_W:0]        rr_sum;
  logic                  rr_hit;
  logic [IDX_W-1:0]      rr_idx;
  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;

  for (genvar j = 0; j < NUM_REQ; j++) begin : g_slice
    assign slices[j] = req_data[j*DATA_W +: DATA_W];
  end

  // Round-robin search starting one past the last granted source.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    rr_sum = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_sum = {1'b0, last} + (IDX_W+1)'(k);
      if (rr_sum >= (IDX_W+1)'(NUM_REQ))
        rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
      if (!rr_hit && req[rr_sum[IDX_W-1:0]]) begin
        rr_hit = 1'b1;
        rr_idx = rr_sum[IDX_W-1:0];
      end
    end
  end

  // While locked only the lock owner may be granted.
  assign pick_valid = locked ? req[owner] : rr_hit;
  assign pick_idx   = locked ? owner : rr_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= IDX_INIT;
      grant    <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      owner    <= '0;
      locked   <= 1'b0;
      arb_busy <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last     <= last_nxt;
      grant    <= grant_nxt;
      tx_data  <= tx_data_nxt;
      tx_start <= tx_start_nxt;
      owner    <= owner_nxt;
      locked   <= locked_nxt;
      arb_busy <= (state_nxt != IDLE);
      ack_err  <= ack_err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (pick_valid) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (tx_busy)              state_nxt = WAIT_DONE;
        else if (cnt == ACK_LAST) state_nxt = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_nxt    = '0;
    tx_start_nxt = 1'b0;
    ack_err_nxt  = 1'b0;
    tx_data_nxt  = tx_data;
    owner_nxt    = owner;
    last_nxt     = last;
    locked_nxt   = locked;
    cnt_nxt      = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_nxt   = NUM_REQ'(1) << pick_idx;
          tx_data_nxt = slices[pick_idx];
          owner_nxt   = pick_idx;
          last_nxt    = pick_idx;
          locked_nxt  = !req_last[pick_idx];
        end else if (locked) begin
          // Stalled lock owner: release after LOCK_TIMEOUT idle cycles.
          if (cnt == LOCK_LAST) locked_nxt = 1'b0;
          else                  cnt_nxt    = cnt + 1'b1;
        end
      end
      ISSUE: tx_start_nxt = 1'b1;
      WAIT_ACK: begin
        if (!tx_busy) begin
          // No busy response: the byte is dropped, not regranted.
          if (cnt == ACK_LAST) begin
            ack_err_nxt = 1'b1;
            locked_nxt  = 1'b0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-source byte queues drive requests, a simple
// transmitter model answers tx_start, and a scoreboard checks grant order/data.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] req_last = '0;
  logic [31:0] req_data = '0;
  logic [3:0] grant;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic [1:0] owner;
  logic       locked;
  logic       arb_busy;
  logic       ack_err;

  uart_tx_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .ACK_TIMEOUT(4), .LOCK_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_last(req_last),
    .req_data(req_data), .grant(grant), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .owner(owner),
    .locked(locked), .arb_busy(arb_busy), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  typedef struct { int src; logic [7:0] data; logic last; } byte_t;
  typedef struct { int src; logic [7:0] data; } exp_t;
  typedef struct { int src; logic [7:0] data; logic last; int exp_src; logic [7:0] exp_data; } vec_t;

  byte_t srcq[$];
  exp_t  expq[$];
  vec_t  vecs[13];

  int checks = 0;
  int failures = 0;
  int busy_len = 2;
  int busy_rem = 0;
  bit pend_start = 1'b0;
  int mon_gi;
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input int s, input logic [7:0] d, input logic l);
    byte_t b;
    b.src = s; b.data = d; b.last = l;
    srcq.push_back(b);
  endtask

  task automatic expect_grant(input int s, input logic [7:0] d);
    exp_t e;
    e.src = s; e.data = d;
    expq.push_back(e);
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      load(vecs[i].src, vecs[i].data, vecs[i].last);
      expect_grant(vecs[i].exp_src, vecs[i].exp_data);
    end
  endtask

  task automatic wait_grant(input logic [3:0] g, input int budget, input string name);
    bit ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(posedge clk); #1;
      if (grant == g) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: no grant=%b within %0d cycles", name, g, budget);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(posedge clk); #1;
      if (!arb_busy) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: arb_busy still high after %0d cycles", name, budget);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(posedge clk); #1;
      if (expq.size() == 0 && srcq.size() == 0 && !arb_busy) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: %0d grants still expected after %0d cycles", name, expq.size(), budget);
    end
  endtask

  // Scoreboard monitor, transmitter model and requester driver.
  always @(negedge clk) begin
    if (pend_start) begin
      chk("tx_start_after_grant", {31'd0, tx_start}, 32'd1);
      chk("grant_clear_after_grant", {28'd0, grant}, 32'd0);
      pend_start = 1'b0;
    end
    if (grant != 4'b0000) begin
      chk("grant_onehot", {31'd0, $onehot(grant)}, 32'd1);
      mon_gi = 0;
      for (int i = 0; i < 4; i++) if (grant[i]) mon_gi = i;
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_grant: got grant=%b expected none", grant);
      end else begin
        mon_e = expq.pop_front();
        chk("sb_grant_src", mon_gi, mon_e.src);
        chk("sb_tx_data", {24'd0, tx_data}, {24'd0, mon_e.data});
      end
      begin
        int hit;
        hit = -1;
        for (int i = 0; i < srcq.size(); i++) if (hit < 0 && srcq[i].src == mon_gi) hit = i;
        if (hit >= 0) srcq.delete(hit);
      end
      pend_start = 1'b1;
    end
    if (!reset_n) begin
      tx_busy = 1'b0; busy_rem = 0; pend_start = 1'b0;
    end else if (tx_start && busy_len > 0) begin
      tx_busy = 1'b1; busy_rem = busy_len - 1;
    end else if (busy_rem > 0) begin
      busy_rem--;
    end else begin
      tx_busy = 1'b0;
    end
    req = '0; req_last = '0; req_data = '0;
    for (int s = 0; s < 4; s++)
      for (int i = srcq.size() - 1; i >= 0; i--)
        if (srcq[i].src == s) begin
          req[s] = 1'b1;
          req_last[s] = srcq[i].last;
          req_data[s*8 +: 8] = srcq[i].data;
        end
  end

  initial begin
    int n;
    logic [2:0] lock_exp;
    int nl;
    // Fairness: pointer sits at 0 after the single-source byte.
    vecs[0]  = '{0, 8'h10, 1'b1, 1, 8'h11};
    vecs[1]  = '{1, 8'h11, 1'b1, 2, 8'h12};
    vecs[2]  = '{2, 8'h12, 1'b1, 3, 8'h13};
    vecs[3]  = '{3, 8'h13, 1'b1, 0, 8'h10};
    vecs[4]  = '{0, 8'h14, 1'b1, 1, 8'h15};
    vecs[5]  = '{1, 8'h15, 1'b1, 2, 8'h16};
    vecs[6]  = '{2, 8'h16, 1'b1, 3, 8'h17};
    vecs[7]  = '{3, 8'h17, 1'b1, 0, 8'h14};
    // Packet lock: source 2 three-byte packet against continuous source 0.
    vecs[8]  = '{2, 8'hA0, 1'b0, 2, 8'hA0};
    vecs[9]  = '{2, 8'hA1, 1'b0, 2, 8'hA1};
    vecs[10] = '{2, 8'hA2, 1'b1, 2, 8'hA2};
    vecs[11] = '{0, 8'hB0, 1'b1, 0, 8'hB0};
    vecs[12] = '{0, 8'hB1, 1'b1, 0, 8'hB1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_arb_busy", {31'd0, arb_busy}, 32'd0);
    chk("rst_ack_err", {31'd0, ack_err}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single source with a 10-cycle transmitter.
    busy_len = 10;
    load(0, 8'h41, 1'b1);
    expect_grant(0, 8'h41);
    wait_grant(4'b0001, 10, "t1_grant");
    chk("t1_tx_data", {24'd0, tx_data}, 32'h41);
    chk("t1_owner", {30'd0, owner}, 32'd0);
    chk("t1_arb_busy", {31'd0, arb_busy}, 32'd1);
    chk("t1_locked", {31'd0, locked}, 32'd0);
    @(posedge clk); #1;
    chk("t1_tx_start", {31'd0, tx_start}, 32'd1);
    for (n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (!arb_busy) break;
    end
    chk("t1_busy_cycles", n, 11);
    chk("t1_tx_busy_low", {31'd0, tx_busy}, 32'd0);

    // Fairness over two rounds.
    busy_len = 2;
    apply(0, 8);
    wait_drain(300, "t2_drain");
    chk("t2_owner", {30'd0, owner}, 32'd0);

    // Packet lock.
    apply(8, 13);
    lock_exp = 3'b011;
    nl = 0;
    for (int c = 0; c < 200 && nl < 3; c++) begin
      @(posedge clk); #1;
      if (grant == 4'b0100) begin
        chk("t3_locked", {31'd0, locked}, {31'd0, lock_exp[nl]});
        chk("t3_owner", {30'd0, owner}, 32'd2);
        nl++;
      end
    end
    chk("t3_src2_grants", nl, 3);
    wait_drain(200, "t3_drain");

    // Lock timeout: source 1 stalls mid-packet while source 3 waits.
    load(1, 8'h31, 1'b0);
    load(3, 8'h33, 1'b1);
    expect_grant(1, 8'h31);
    expect_grant(3, 8'h33);
    wait_grant(4'b0010, 10, "t4_grant1");
    chk("t4_locked_set", {31'd0, locked}, 32'd1);
    wait_idle(20, "t4_idle");
    for (n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (!locked) break;
    end
    chk("t4_lock_timeout_cycles", n, 8);
    chk("t4_no_grant_at_timeout", {28'd0, grant}, 32'd0);
    @(posedge clk); #1;
    chk("t4_grant3", {28'd0, grant}, 32'b1000);
    wait_drain(100, "t4_drain");

    // Ack timeout: transmitter never goes busy.
    busy_len = 0;
    load(2, 8'h52, 1'b1);
    expect_grant(2, 8'h52);
    wait_grant(4'b0100, 10, "t5_grant");
    @(posedge clk); #1;
    chk("t5_tx_start", {31'd0, tx_start}, 32'd1);
    for (n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (ack_err) break;
    end
    chk("t5_ack_err_cycles", n, 4);
    chk("t5_arb_idle", {31'd0, arb_busy}, 32'd0);
    @(posedge clk); #1;
    chk("t5_ack_err_pulse", {31'd0, ack_err}, 32'd0);
    chk("t5_no_regrant", {28'd0, grant}, 32'd0);
    busy_len = 2;
    load(1, 8'h61, 1'b1);
    expect_grant(1, 8'h61);
    wait_drain(100, "t5_drain");

    // Reset during WAIT_DONE, then pointer must be back at NUM_REQ-1.
    busy_len = 10;
    load(1, 8'h71, 1'b0);
    expect_grant(1, 8'h71);
    wait_grant(4'b0010, 10, "t6_grant");
    chk("t6_locked", {31'd0, locked}, 32'd1);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_grant", {28'd0, grant}, 32'd0);
    chk("t6_rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("t6_rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("t6_rst_owner", {30'd0, owner}, 32'd0);
    chk("t6_rst_locked", {31'd0, locked}, 32'd0);
    chk("t6_rst_arb_busy", {31'd0, arb_busy}, 32'd0);
    chk("t6_rst_ack_err", {31'd0, ack_err}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    busy_len = 2;
    load(0, 8'h80, 1'b1);
    load(2, 8'h82, 1'b1);
    expect_grant(0, 8'h80);
    expect_grant(2, 8'h82);
    wait_grant(4'b0001, 10, "t6_grant0_first");
    wait_drain(100, "t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
